// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration sequencer: FSM states, register offsets, beat order.
// The order writes ctrl last so a channel only enables once period/divisor/duty are in place.
package pwm_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PERIOD = 2'd1;
    localparam logic [1:0] OFS_DIV    = 2'd2;
    localparam logic [1:0] OFS_DC     = 2'd3;

    localparam int NUM_BEATS = 4;

    function automatic logic [1:0] beat_ofs(input logic [1:0] beat);
        case (beat)
            2'd0:    return OFS_PERIOD;
            2'd1:    return OFS_DIV;
            2'd2:    return OFS_DC;
            default: return OFS_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
// Zero latency; no backpressure, the caller decides when to sample the grant.
module rr_arbiter #(
    parameter int num_ch    = 4,
    parameter int ptr_width = (num_ch > 1) ? $clog2(num_ch) : 1
) (
    input  logic [num_ch-1:0]    req,
    input  logic [ptr_width-1:0] ptr,
    output logic [num_ch-1:0]    gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_ch; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_ch) begin
                idx = idx - num_ch;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Serves per-channel config requests round-robin, writing 4 Wishbone beats per grant (ctrl last).
// First stb one cycle after grant; each beat waits for i_wb_ack up to timeout cycles, then aborts with o_err.
module pwm_cfg_sequencer
    import pwm_cfg_pkg::*;
#(
    parameter int num_ch    = 4,
    parameter int mem_width = 16,
    parameter int adr_width = 16,
    parameter int timeout   = 15
) (
    input  logic                          i_wb_clk,
    input  logic                          i_wb_rst,
    input  logic [num_ch-1:0]             i_req,
    input  logic [num_ch*4*mem_width-1:0] i_cfg_data,
    output logic [num_ch-1:0]             o_done,
    output logic [num_ch-1:0]             o_err,
    output logic                          o_busy,
    output logic                          o_wb_cyc,
    output logic                          o_wb_stb,
    output logic                          o_wb_we,
    output logic [adr_width-1:0]          o_wb_adr,
    output logic [mem_width-1:0]          o_wb_data,
    input  logic                          i_wb_ack
);

    localparam int CW = (num_ch > 1) ? $clog2(num_ch) : 1;
    localparam int TW = (timeout > 1) ? $clog2(timeout + 1) : 1;
    localparam int WW = 4 * mem_width;
    localparam logic [TW-1:0] CNT_LAST  = TW'(timeout - 1);
    localparam logic [1:0]    BEAT_LAST = 2'(NUM_BEATS - 1);

    state_t          state;
    logic [CW-1:0]   ch;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   gnt_idx;
    logic [CW-1:0]   ch_next;
    logic [num_ch-1:0] gnt;
    logic [1:0]      beat;
    logic [TW-1:0]   cnt;
    logic [WW-1:0]   snap;
    logic [WW-1:0]   gnt_words;

    rr_arbiter #(
        .num_ch    (num_ch),
        .ptr_width (CW)
    ) u_rr_arbiter (
        .req (i_req),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < num_ch; i++) begin
            if (gnt[i]) begin
                gnt_idx = CW'(i);
            end
        end
    end

    assign gnt_words = i_cfg_data[int'(gnt_idx)*WW +: WW];
    assign ch_next   = (int'(ch) == num_ch - 1) ? '0 : ch + CW'(1);

    function automatic logic [adr_width-1:0] beat_adr(input logic [CW-1:0] c, input logic [1:0] ofs);
        return adr_width'(int'(c) * 4 + int'(ofs));
    endfunction

    function automatic logic [mem_width-1:0] word_of(input logic [WW-1:0] w, input logic [1:0] ofs);
        return w[int'(ofs)*mem_width +: mem_width];
    endfunction

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state     <= S_IDLE;
            ch        <= '0;
            rr_ptr    <= '0;
            beat      <= '0;
            cnt       <= '0;
            snap      <= '0;
            o_done    <= '0;
            o_err     <= '0;
            o_busy    <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_data <= '0;
        end else begin
            o_done <= '0;
            o_err  <= '0;
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        // Snapshot all four words so later i_cfg_data changes cannot tear the update.
                        ch        <= gnt_idx;
                        snap      <= gnt_words;
                        beat      <= 2'd0;
                        cnt       <= '0;
                        state     <= S_WRITE;
                        o_busy    <= 1'b1;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b1;
                        o_wb_adr  <= beat_adr(gnt_idx, beat_ofs(2'd0));
                        o_wb_data <= word_of(gnt_words, beat_ofs(2'd0));
                    end
                end
                S_WRITE: begin
                    if (i_wb_ack) begin
                        o_wb_stb  <= 1'b0;
                        o_wb_we   <= 1'b0;
                        o_wb_adr  <= '0;
                        o_wb_data <= '0;
                        if (beat == BEAT_LAST) begin
                            state     <= S_DONE;
                            o_wb_cyc  <= 1'b0;
                            o_done[ch] <= 1'b1;
                        end else begin
                            state <= S_GAP;
                            beat  <= beat + 2'd1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state      <= S_ERR;
                        o_wb_cyc   <= 1'b0;
                        o_wb_stb   <= 1'b0;
                        o_wb_we    <= 1'b0;
                        o_wb_adr   <= '0;
                        o_wb_data  <= '0;
                        o_err[ch]  <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    state     <= S_WRITE;
                    cnt       <= '0;
                    o_wb_stb  <= 1'b1;
                    o_wb_we   <= 1'b1;
                    o_wb_adr  <= beat_adr(ch, beat_ofs(beat));
                    o_wb_data <= word_of(snap, beat_ofs(beat));
                end
                S_DONE, S_ERR: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    rr_ptr <= ch_next;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Randomized bench for pwm_cfg_sequencer against a round-robin write-sequence model.
module tb_pwm_cfg_sequencer;

    localparam int NCH = 4;
    localparam int MW  = 16;
    localparam int AW  = 16;
    localparam int TO  = 15;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NCH-1:0]        req = '0;
    logic [NCH*4*MW-1:0]   cfg = '0;
    logic [NCH-1:0]        o_done, o_err;
    logic                  o_busy, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]         o_wb_adr;
    logic [MW-1:0]         o_wb_data;
    logic                  ack = 1'b0;
    logic                  slave_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    int bad_bus  = 0;
    int overlap  = 0;
    int ord [4]  = '{1, 2, 3, 0};

    logic [AW+MW-1:0] wr_q[$], exp_wr[$];
    int               done_q[$], exp_done[$], err_q[$];

    always #5 clk = ~clk;

    pwm_cfg_sequencer #(.num_ch(NCH), .mem_width(MW), .adr_width(AW), .timeout(TO)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (rst),
        .i_req      (req),
        .i_cfg_data (cfg),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_busy     (o_busy),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_adr   (o_wb_adr),
        .o_wb_data  (o_wb_data),
        .i_wb_ack   (ack)
    );

    // Slave: acknowledges one cycle after stb is seen.
    always @(posedge clk) ack <= slave_en && o_wb_cyc && o_wb_stb && !ack;

    always @(negedge clk) begin
        if (o_wb_cyc && o_wb_stb && o_wb_we && ack) wr_q.push_back({o_wb_adr, o_wb_data});
        if (!o_wb_stb && (o_wb_adr != '0 || o_wb_data != '0)) bad_bus++;
        if ($countones(o_done | o_err) > 1) overlap++;
        for (int i = 0; i < NCH; i++) begin
            if (o_done[i]) done_q.push_back(i);
            if (o_err[i]) err_q.push_back(i);
        end
    end

    task automatic clear_queues;
        wr_q.delete(); exp_wr.delete(); done_q.delete(); exp_done.delete(); err_q.delete();
    endtask

    task automatic randomize_cfg;
        for (int i = 0; i < NCH * 4; i++) cfg[i*MW +: MW] = MW'($urandom());
    endtask

    // Expected behaviour: serve requested channels one at a time, each search starting after the last served.
    task automatic model_grant(input logic [NCH-1:0] mask);
        logic [NCH-1:0] rem;
        int c;
        rem = mask;
        while (rem != '0) begin
            c = ptr_m;
            while (!rem[c]) c = (c + 1) % NCH;
            rem[c] = 1'b0;
            exp_done.push_back(c);
            foreach (ord[k]) exp_wr.push_back({AW'(c * 4 + ord[k]), cfg[(c*4 + ord[k])*MW +: MW]});
            ptr_m = (c + 1) % NCH;
        end
    endtask

    task automatic run_until_quiet(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            req = req & ~(o_done | o_err);
            if (req == '0 && !o_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0;
        @(negedge clk);
        n_checks++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {o_wb_cyc, o_wb_stb, o_wb_we}); end
        n_checks++; if (o_wb_adr !== '0) begin n_fail++; $display("FAIL reset_adr: got %h expected 0", o_wb_adr); end
        n_checks++; if (o_wb_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_wb_data); end
        n_checks++; if ({o_done, o_err} !== '0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b expected 0", o_done, o_err); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_single;
        bit to;
        @(negedge clk);
        clear_queues();
        randomize_cfg();
        cfg[4*MW +: MW] = 16'h0001; cfg[5*MW +: MW] = 16'h00FF;
        cfg[6*MW +: MW] = 16'h0004; cfg[7*MW +: MW] = 16'h0080;
        model_grant(4'b0010);
        req = 4'b0010;
        run_until_quiet(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got busy expected idle"); end
        n_checks++; if (wr_q.size() != 4 || wr_q[0] !== {16'd5, 16'h00FF}) begin n_fail++; $display("FAIL single_first_write: got %0d writes, first %h expected 000500ff", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0); end
        n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL single_wr_count: got %0d expected %0d", wr_q.size(), exp_wr.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) begin
            n_checks++; if (wr_q[k] !== exp_wr[k]) begin n_fail++; $display("FAIL single_wr[%0d]: got %h expected %h", k, wr_q[k], exp_wr[k]); end
        end
        n_checks++; if (done_q != exp_done) begin n_fail++; $display("FAIL single_done: got %0d pulses expected %0d", done_q.size(), exp_done.size()); end
        n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL single_err: got %0d expected 0", err_q.size()); end
    endtask

    task automatic test_back_to_back;
        bit to;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        clear_queues();
        randomize_cfg();
        model_grant(4'b1111);
        req = 4'b1111;
        run_until_quiet(400, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got busy expected idle"); end
        n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_q.size(), exp_wr.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) begin
            n_checks++; if (wr_q[k] !== exp_wr[k]) begin n_fail++; $display("FAIL b2b_wr[%0d]: got %h expected %h", k, wr_q[k], exp_wr[k]); end
        end
        n_checks++; if (done_q.size() != exp_done.size()) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected %0d", done_q.size(), exp_done.size()); end
        for (int k = 0; k < done_q.size() && k < exp_done.size(); k++) begin
            n_checks++; if (done_q[k] != exp_done[k]) begin n_fail++; $display("FAIL b2b_order[%0d]: got ch%0d expected ch%0d", k, done_q[k], exp_done[k]); end
        end
    endtask

    task automatic test_timeout;
        int stb_cycles = 0;
        @(negedge clk);
        clear_queues();
        slave_en = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_wb_stb) stb_cycles++;
            if (o_err != '0) break;
        end
        n_checks++; if (stb_cycles != TO) begin n_fail++; $display("FAIL timeout_len: got %0d cycles expected %0d", stb_cycles, TO); end
        n_checks++; if (o_err !== 4'b0100) begin n_fail++; $display("FAIL timeout_err: got %b expected 0100", o_err); end
        n_checks++; if (o_wb_cyc !== 1'b0 || o_done !== '0) begin n_fail++; $display("FAIL timeout_cyc: got cyc=%b done=%b expected 0/0", o_wb_cyc, o_done); end
        req = '0;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b expected 0", o_busy); end
        slave_en = 1'b1;
        ptr_m = 3;
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        bit to;
        @(negedge clk);
        clear_queues();
        req = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_wb_stb && o_wb_adr == AW'(3)) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach: got no beat 2 expected adr 3"); end
        rst = 1'b1; req = '0;
        @(negedge clk);
        n_checks++; if ({o_wb_cyc, o_wb_stb, o_busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_bus: got %b expected 000", {o_wb_cyc, o_wb_stb, o_busy}); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (done_q.size() != 0 || err_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pulse: got %0d done %0d err expected 0", done_q.size(), err_q.size()); end
        n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL rstmid_partial: got %0d writes expected 2", wr_q.size()); end
        clear_queues();
        ptr_m = 0;
        model_grant(4'b0001);
        req = 4'b0001;
        run_until_quiet(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: got busy expected idle"); end
        n_checks++; if (wr_q.size() == 0 || wr_q[0][AW+MW-1:MW] !== AW'(1)) begin n_fail++; $display("FAIL rstmid_restart: got %0d writes expected first adr 1", wr_q.size()); end
        n_checks++; if (wr_q != exp_wr || done_q != exp_done) begin n_fail++; $display("FAIL rstmid_seq: got %0d writes/%0d done expected %0d/%0d", wr_q.size(), done_q.size(), exp_wr.size(), exp_done.size()); end
    endtask

    task automatic test_snapshot;
        bit to;
        bit seen = 1'b0;
        int c;
        @(negedge clk);
        clear_queues();
        randomize_cfg();
        c = $urandom_range(0, NCH - 1);
        model_grant(NCH'(1 << c));
        req = NCH'(1 << c);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_busy) begin seen = 1'b1; break; end
        end
        randomize_cfg();
        req = '0;
        run_until_quiet(200, to);
        n_checks++; if (!seen || to) begin n_fail++; $display("FAIL snap_handshake: got seen=%b timeout=%b expected 1/0", seen, to); end
        n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL snap_wr_count: got %0d expected %0d", wr_q.size(), exp_wr.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) begin
            n_checks++; if (wr_q[k] !== exp_wr[k]) begin n_fail++; $display("FAIL snap_wr[%0d]: got %h expected %h", k, wr_q[k], exp_wr[k]); end
        end
        n_checks++; if (done_q != exp_done) begin n_fail++; $display("FAIL snap_done: got %0d pulses expected %0d", done_q.size(), exp_done.size()); end
    endtask

    task automatic test_random;
        bit to;
        logic [NCH-1:0] mask;
        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            clear_queues();
            randomize_cfg();
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            model_grant(mask);
            req = mask;
            run_until_quiet(400, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got busy expected idle", r); end
            n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL rand%0d_wr_count: got %0d expected %0d", r, wr_q.size(), exp_wr.size()); end
            for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) begin
                n_checks++; if (wr_q[k] !== exp_wr[k]) begin n_fail++; $display("FAIL rand%0d_wr[%0d]: got %h expected %h", r, k, wr_q[k], exp_wr[k]); end
            end
            n_checks++; if (done_q != exp_done) begin n_fail++; $display("FAIL rand%0d_done: got %0d pulses expected %0d", r, done_q.size(), exp_done.size()); end
        end
    endtask

    task automatic test_bus_rules;
        n_checks++; if (bad_bus != 0) begin n_fail++; $display("FAIL bus_idle_zero: got %0d violations expected 0", bad_bus); end
        n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d violations expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_snapshot();
        test_random();
        test_bus_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
